// File: rtl/led_bar_phase_ctrl.sv
// led_bar_phase_ctrl: 13-LED bar phase sequencer (charge/armed/discharge/done/fail) with tick prescaler
// Ports: CLOCK, RESET (async, active-high); start/correct/abort requests;
//        LED[12:0] bar (bit 12 leftmost); phase[2:0]; empty (DONE); fail (FAIL); tick (prescaler pulse)
module led_bar_phase_ctrl #(
    parameter int TICK_DIV      = 10_000_000,
    parameter int TIMEOUT_TICKS = 50
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        start,
    input  logic        correct,
    input  logic        abort,
    output logic [12:0] LED,
    output logic [2:0]  phase,
    output logic        empty,
    output logic        fail,
    output logic        tick
);
    localparam int CW = $clog2(TICK_DIV);
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] CHARGE    = 3'd1;
    localparam logic [2:0] ARMED     = 3'd2;
    localparam logic [2:0] DISCHARGE = 3'd3;
    localparam logic [2:0] DONE      = 3'd4;
    localparam logic [2:0] FAILED    = 3'd5;
    logic [2:0]    phase_q, phase_d;
    logic [12:0]   led_q, led_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] to_q, to_d, to_inc;
    logic          empty_q, fail_q;
    assign tick   = (phase_q != IDLE) && (cnt_q == CW'(TICK_DIV - 1));
    assign to_inc = to_q + TW'(1);
    assign LED    = led_q;
    assign phase  = phase_q;
    assign empty  = empty_q;
    assign fail   = fail_q;
    always_comb begin
        phase_d = phase_q;
        led_d   = led_q;
        to_d    = to_q;
        cnt_d   = (phase_q == IDLE || tick) ? '0 : cnt_q + CW'(1);
        if (abort) begin
            phase_d = IDLE;
            led_d   = '0;
            cnt_d   = '0;
            to_d    = '0;
        end else if (start && (phase_q == IDLE || phase_q == DONE || phase_q == FAILED)) begin
            phase_d = CHARGE;
            led_d   = '0;
            cnt_d   = '0;
            to_d    = '0;
        end else begin
            case (phase_q)
                IDLE: begin
                    led_d = '0;
                    to_d  = '0;
                end
                CHARGE: if (tick) begin
                    led_d   = {led_q[11:0], 1'b1};
                    phase_d = &led_q[11:0] ? ARMED : CHARGE;
                    to_d    = '0;
                end
                ARMED: if (tick) begin
                    phase_d = correct ? DISCHARGE : (to_inc == TW'(TIMEOUT_TICKS)) ? FAILED : ARMED;
                    led_d   = correct ? led_q >> 1 : led_q;
                    to_d    = correct ? '0 : to_inc;
                end
                DISCHARGE: if (tick) begin
                    phase_d = correct ? ((led_q >> 1) == '0 ? DONE : DISCHARGE) : ARMED;
                    led_d   = correct ? led_q >> 1 : 13'h1FFF;
                    to_d    = '0;
                end
                DONE: led_d = '0;
                FAILED: if (tick) led_d = ~led_q;
                default: begin
                    phase_d = IDLE;
                    led_d   = '0;
                    cnt_d   = '0;
                    to_d    = '0;
                end
            endcase
        end
    end
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            phase_q <= IDLE;
            led_q   <= '0;
            cnt_q   <= '0;
            to_q    <= '0;
            empty_q <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            led_q   <= led_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            empty_q <= (phase_d == DONE);
            fail_q  <= (phase_d == FAILED);
        end
    end
endmodule

// File: tb/tb_led_bar_phase_ctrl.sv
// tb_led_bar_phase_ctrl: scoreboard bench for led_bar_phase_ctrl against a level/phase reference model
module tb_led_bar_phase_ctrl;
    localparam int TD = 4;
    localparam int TT = 3;
    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        start = 1'b0;
    logic        correct = 1'b0;
    logic        abort = 1'b0;
    logic [12:0] LED;
    logic [2:0]  phase;
    logic        empty, fail, tick;
    int vecs = 0;
    int errs = 0;
    logic [18:0] q[$];
    int m_ph = 0, m_lvl = 0, m_pc = 0, m_miss = 0;
    bit m_fon = 1'b0;

    led_bar_phase_ctrl #(.TICK_DIV(TD), .TIMEOUT_TICKS(TT)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .start(start), .correct(correct), .abort(abort),
        .LED(LED), .phase(phase), .empty(empty), .fail(fail), .tick(tick)
    );

    always #5 CLOCK = ~CLOCK;

    function automatic logic [18:0] exp_out();
        logic [12:0] l;
        l = (m_ph == 5) ? (m_fon ? 13'h1FFF : 13'h0) : 13'((1 << m_lvl) - 1);
        return {l, 3'(m_ph), m_ph == 4, m_ph == 5, (m_ph != 0) && (m_pc % TD == TD - 1)};
    endfunction

    task automatic model_reset();
        m_ph = 0; m_lvl = 0; m_pc = 0; m_miss = 0; m_fon = 1'b0;
    endtask

    // One clock of the game rules: bar height as a count of lit LEDs, ticks from cycles since start
    task automatic model_step(input bit a, input bit s, input bit c);
        bit t;
        t = (m_ph != 0) && (m_pc % TD == TD - 1);
        if (a) model_reset();
        else if (s && (m_ph == 0 || m_ph == 4 || m_ph == 5)) begin
            m_ph = 1; m_lvl = 0; m_pc = 0; m_miss = 0;
        end else begin
            if (m_ph != 0) m_pc++;
            if (t) begin
                if (m_ph == 1) begin
                    m_lvl++;
                    if (m_lvl == 13) begin m_ph = 2; m_miss = 0; end
                end else if (m_ph == 2) begin
                    if (c) begin m_ph = 3; m_lvl = 12; m_miss = 0; end
                    else begin
                        m_miss++;
                        if (m_miss == TT) begin m_ph = 5; m_fon = 1'b1; end
                    end
                end else if (m_ph == 3) begin
                    if (c) begin
                        m_lvl--;
                        if (m_lvl == 0) m_ph = 4;
                    end else begin m_ph = 2; m_lvl = 13; m_miss = 0; end
                end else if (m_ph == 5) m_fon = !m_fon;
            end
        end
    endtask

    task automatic cyc(input bit a, input bit s, input bit c);
        @(negedge CLOCK);
        RESET = 1'b0; abort = a; start = s; correct = c;
        model_step(a, s, c);
        q.push_back(exp_out());
    endtask

    task automatic run(input int n, input bit c);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, c);
    endtask

    // Assert RESET mid-cycle and require reset outputs before the next edge
    task automatic async_reset();
        @(negedge CLOCK);
        abort = 1'b0; start = 1'b0; correct = 1'b0;
        model_reset();
        q.push_back(exp_out());
        #2 RESET = 1'b1;
        #1 vecs++;
        if ({LED, phase, empty, fail, tick} !== 19'h0) begin
            errs++;
            $display("FAIL async_reset got LED=%h phase=%0d empty=%b fail=%b tick=%b want all zero",
                     LED, phase, empty, fail, tick);
        end
    endtask

    initial begin
        forever begin
            @(posedge CLOCK);
            #1;
            if (q.size() > 0) begin
                logic [18:0] e;
                e = q.pop_front();
                vecs++;
                if ({LED, phase, empty, fail, tick} !== e) begin
                    errs++;
                    $display("FAIL out t=%0t got LED=%h phase=%0d empty=%b fail=%b tick=%b want LED=%h phase=%0d empty=%b fail=%b tick=%b",
                             $time, LED, phase, empty, fail, tick, e[18:6], e[5:3], e[2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            @(negedge CLOCK);
            RESET = 1'b1;
            model_reset();
            q.push_back(exp_out());
        end
        run(20, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        run(54, 1'b1);
        run(60, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        run(52, 1'b0);
        run(20, 1'b1);
        run(4, 1'b0);
        run(4, 1'b1);
        run(16, 1'b0);
        run(16, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        run(52, 1'b0);
        run(28, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        run(54, 1'b0);
        run(26, 1'b1);
        async_reset();
        run(5, 1'b0);
        for (int seg = 0; seg < 120; seg++) begin
            int len, pc;
            len = $urandom_range(10, 60);
            pc = $urandom_range(0, 10);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 999) == 0) async_reset();
                else cyc($urandom_range(0, 399) == 0, $urandom_range(0, 29) == 0,
                         $urandom_range(0, 9) < pc);
            end
        end
        @(negedge CLOCK);
        abort = 1'b0; start = 1'b0; correct = 1'b0;
        repeat (3) @(negedge CLOCK);
        vecs++;
        if (q.size() != 0) begin
            errs++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/led_bar_phase_ctrl.md
# led_bar_phase_ctrl

Phase controller for the 13-LED bar used by the discharge game. Sequences the bar through charge (fill right-to-left), armed (wait for `correct`), discharge (extinguish left-to-right while `correct` holds), done and fail phases, with its own tick prescaler. It is the single owner of the LED bar and exposes phase and status flags to the top-level game FSM.

## Interface
- `TICK_DIV`, 10_000_000: CLOCK cycles per tick (10 Hz at 100 MHz); minimum 2.
- `TIMEOUT_TICKS`, 50: consecutive ticks with `correct`=0 in ARMED before FAIL; minimum 1.
- `CLOCK` in 1: system clock; all logic on posedge.
- `RESET` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to begin a round; level-tolerant, sampled every cycle.
- `correct` in 1: level from the answer checker; sampled only on tick cycles.
- `abort` in 1: return to IDLE; highest priority.
- `LED` out 13: bar drive; bit 12 is leftmost.
- `phase` out 3: 0 IDLE, 1 CHARGE, 2 ARMED, 3 DISCHARGE, 4 DONE, 5 FAIL.
- `empty` out 1: high exactly while in DONE.
- `fail` out 1: high exactly while in FAIL.
- `tick` out 1: one-cycle prescaler pulse, for observation.

## Operation
- Prescaler: counter 0..TICK_DIV-1, free-running while phase≠IDLE. `tick`=1 in the cycle count==TICK_DIV-1. Counter is held at 0 in IDLE and cleared to 0 on the edge that accepts `start`.
- Priority per edge: `abort` > `start` > tick-driven transitions.
- `abort`=1: next state IDLE, LED=0, counters cleared, from any state.
- IDLE: LED=0. `start` -> CHARGE, LED=0.
- CHARGE: on tick, LED <= {LED[11:0],1}. The tick that sets LED=13'h1FFF also moves to ARMED (13 ticks total). `start` is ignored.
- ARMED: LED=13'h1FFF. On tick:
  - `correct`=1: go to DISCHARGE, LED <= LED>>1 (13'h0FFF), clear timeout.
  - `correct`=0: timeout++. When the incremented value equals TIMEOUT_TICKS, go to FAIL.
  - `start` is ignored.
- DISCHARGE: on tick:
  - `correct`=1: LED <= LED>>1. The tick producing LED=0 moves to DONE.
  - `correct`=0: LED <= 13'h1FFF, go to ARMED, timeout=0 (the bar recharges fully).
  - `start` is ignored.
- DONE: LED=0, `empty`=1. `start` -> CHARGE.
- FAIL: on each tick LED toggles between 13'h1FFF and 0. The first FAIL value is 13'h1FFF, held from entry. `fail`=1. `start` -> CHARGE with LED=0.
- Timeout counter: width clog2(TIMEOUT_TICKS+1). Cleared on entry to ARMED and on IDLE. Never wraps.
- Illegal state encodings (6, 7) recover to IDLE on the next edge, LED=0.

## Timing
- All outputs are registered except `tick`, which decodes the registered counter.
- `RESET` asserted: LED=0, phase=0, `empty`=0, `fail`=0, `tick`=0, prescaler and timeout at 0. Takes effect immediately.
- `RESET` deassertion: the first edge evaluates normally.
- Tick-driven updates land on the edge that ends the tick cycle and are visible the following cycle.
- After `start` is accepted, the first tick occurs TICK_DIV cycles later. Full charge completes 13·TICK_DIV cycles after acceptance.
- Minimum discharge: 13 ticks of `correct`=1 from ARMED to DONE.
- `start` and a tick in the same cycle in DONE/FAIL: `start` wins and the prescaler restarts.
- `abort` and `start` together: IDLE.
- Reset mid-round returns to IDLE. No state is retained.

## Test plan
Sim parameters: TICK_DIV=4, TIMEOUT_TICKS=3.
- Reset and idle: hold `RESET` 3 cycles, release with no stimulus for 20 cycles -> LED=0, phase=0, `tick` never asserts.
- Charge: pulse `start` -> LED goes 0x0001, 0x0003, … 0x1FFF, one step per 4 cycles. Phase becomes 2 on the 13th tick, 52 cycles after `start`.
- Full discharge: from ARMED hold `correct`=1 -> LED 0x0FFF, 0x07FF, … 0x0000 over 13 ticks. Phase=4 and `empty`=1 from the cycle after the 13th tick.
- Recharge on drop: discharge to 0x00FF, then `correct`=0 at the next tick -> LED=0x1FFF, phase=2. Then `correct`=1 -> 0x0FFF.
- Timeout: in ARMED keep `correct`=0 -> phase=5 and `fail`=1 after the 3rd tick. LED then alternates 0x1FFF/0x0000 per tick. `start` -> phase=1, LED=0.
- Abort and reset mid-discharge: `abort` at LED=0x003F -> phase=0, LED=0 next cycle. Repeat using async `RESET` -> outputs reach reset values within the same cycle, before the next edge.
